// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: per-channel debounce
// state encoding and the counter-width helper used to size all counters.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_t;

  // Width able to hold the largest of the three count limits without wrapping.
  function automatic int count_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the button consumers.
// The conditioner takes the slave view; whoever drives the pins and
// consumes the events takes the master view.
interface button_conditioner_if #(
  parameter int NUM_BTN = 2
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_repeat;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_repeat
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_repeat
  );

endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM with consecutive
// sample counter, registered level/press/release outputs and an auto-repeat
// pulse generator active only while the debounced button sits in PRESSED.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int            CW         = count_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RPT_DELAY  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RPT_PERIOD = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic          IDLE_PIN   = (ACTIVE_LOW != 0);

  logic          s1, s2, p;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0] rcnt_q, rcnt_d, rcnt_inc;
  logic [CW-1:0] pcnt_q, pcnt_d, pcnt_inc;
  logic          level_d, press_d, release_d, repeat_d;

  // Pressed-sense of the synchronized pin: idle level maps to 0.
  assign p        = s2 ^ IDLE_PIN;
  assign cnt_inc  = cnt_q + ONE;
  assign rcnt_inc = rcnt_q + ONE;
  assign pcnt_inc = pcnt_q + ONE;

  // Next-state, counter and output decode for the debounce/repeat FSM.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    pcnt_d    = pcnt_q;
    level_d   = level;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (p) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = PRESSED;
            level_d = 1'b1;
            press_d = 1'b1;
            rcnt_d  = '0;
            pcnt_d  = '0;
          end else begin
            state_d = PRESS_PEND;
            cnt_d   = ONE;
          end
        end
      end
      PRESS_PEND: begin
        if (!p) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
          rcnt_d  = '0;
          pcnt_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!p) begin
          rcnt_d = '0;
          pcnt_d = '0;
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = RELEASED;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d = RELEASE_PEND;
            cnt_d   = ONE;
          end
        end else if (REPEAT_DELAY != 0) begin
          // rcnt climbs to the initial delay and then holds; pcnt paces later pulses.
          if (rcnt_q != RPT_DELAY) begin
            rcnt_d   = rcnt_inc;
            repeat_d = (rcnt_inc == RPT_DELAY);
          end else if (REPEAT_PERIOD != 0) begin
            if (pcnt_inc == RPT_PERIOD) begin
              repeat_d = 1'b1;
              pcnt_d   = '0;
            end else begin
              pcnt_d = pcnt_inc;
            end
          end
        end
      end
      RELEASE_PEND: begin
        if (p) begin
          // Bounce back: no pulse, repeat timing starts over from zero.
          state_d = PRESSED;
          cnt_d   = '0;
          rcnt_d  = '0;
          pcnt_d  = '0;
        end else if (cnt_inc == DEB_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  // Synchronizer, FSM state, counters and registered outputs; reset dominates.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      s1            <= IDLE_PIN;
      s2            <= IDLE_PIN;
      state_q       <= RELEASED;
      cnt_q         <= '0;
      rcnt_q        <= '0;
      pcnt_q        <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      s1            <= raw;
      s2            <= s1;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rcnt_q        <= rcnt_d;
      pcnt_q        <= pcnt_d;
      level         <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      repeat_pulse  <= repeat_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: NUM_BTN independent debounce channels whose
// outputs are gathered onto the button interface bit by bit.
module button_conditioner #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 0
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave bus
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .raw          (bus.btn_raw[g]),
      .level        (bus.btn_level[g]),
      .press_pulse  (bus.btn_press[g]),
      .release_pulse(bus.btn_release[g]),
      .repeat_pulse (bus.btn_repeat[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a run-length reference model pushes the
// expected output word every edge, a negedge monitor pops and compares,
// and directed scenarios check press/release/repeat timing on top.
module tb_button_conditioner;

  localparam int NUM_BTN = 2;
  localparam int DEB     = 4;
  localparam int RDLY    = 8;
  localparam int RPER    = 3;

  typedef struct packed {
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] rep;
  } obs_t;

  logic clk = 1'b0;
  logic reset;

  button_conditioner_if #(.NUM_BTN(NUM_BTN)) bus ();

  button_conditioner #(
    .NUM_BTN        (NUM_BTN),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW     (1),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  obs_t exp_q[$];

  // Event log filled by the monitor for the directed timing checks.
  int press_cnt[2], press_edge[2], rel_cnt[2], rel_edge[2];
  int pulse_cnt;
  int rep_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_events();
    for (int c = 0; c < 2; c++) begin
      press_cnt[c]  = 0;
      press_edge[c] = -1;
      rel_cnt[c]    = 0;
      rel_edge[c]   = -1;
    end
    pulse_cnt = 0;
    rep_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reference model: pin delay line, then count consecutive samples that
  // disagree with the accepted level and time how long the accepted press
  // has been stable; pulses follow directly from those run lengths.
  logic [1:0] s1m, s2m, lvl;
  int         run[2], hold[2];

  always @(posedge clk) begin
    obs_t e;
    logic p;
    e = '0;
    edge_cnt++;
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        s1m[c]  = 1'b1;
        s2m[c]  = 1'b1;
        lvl[c]  = 1'b0;
        run[c]  = 0;
        hold[c] = 0;
      end else begin
        p      = ~s2m[c];
        s2m[c] = s1m[c];
        s1m[c] = bus.btn_raw[c];
        if (p != lvl[c]) begin
          run[c]++;
          hold[c] = 0;
          if (run[c] == DEB) begin
            lvl[c] = p;
            run[c] = 0;
            if (p) e.press[c] = 1'b1;
            else   e.rel[c]   = 1'b1;
          end
        end else if (run[c] != 0) begin
          run[c]  = 0;
          hold[c] = 0;
        end else if (lvl[c]) begin
          hold[c]++;
          if (hold[c] == RDLY || (hold[c] > RDLY && RPER > 0 && (hold[c] - RDLY) % RPER == 0))
            e.rep[c] = 1'b1;
        end
      end
      e.level[c] = lvl[c];
    end
    exp_q.push_back(e);
  end

  // Monitor: compare the DUT outputs against the oldest expectation and log events.
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat};
      check($sformatf("outputs_edge%0d", edge_cnt), int'(a), int'(e));
      for (int c = 0; c < 2; c++) begin
        if (a.press[c]) begin press_cnt[c]++; press_edge[c] = edge_cnt; end
        if (a.rel[c])   begin rel_cnt[c]++;   rel_edge[c]   = edge_cnt; end
      end
      if (a.rep[0]) rep_q.push_back(edge_cnt);
      if (a.press != 2'b00 || a.rel != 2'b00 || a.rep != 2'b00) pulse_cnt++;
    end
  end

  initial begin
    int e0, e1, e2, e3, er, pe, first;
    clear_events();
    reset       = 1'b1;
    bus.btn_raw = 2'b11;
    tick(3);
    reset = 1'b0;
    tick(20);
    check("idle_pulses", pulse_cnt, 0);

    // Press on channel 0, held long enough for six repeat pulses.
    clear_events();
    e0          = edge_cnt;
    bus.btn_raw = 2'b10;
    tick(12);
    check("press_latency0", press_edge[0] - e0, 6);
    check("press_once0", press_cnt[0], 1);
    check("press_none1", press_cnt[1], 0);
    pe = press_edge[0];
    tick(25);
    for (int i = 0; i < 6; i++)
      check($sformatf("repeat_%0d", i), (i < rep_q.size()) ? rep_q[i] - pe : -1, RDLY + RPER * i);

    // One-cycle release glitch mid-hold: no release, repeat timing restarts.
    clear_events();
    e1          = edge_cnt;
    bus.btn_raw = 2'b11;
    tick(1);
    bus.btn_raw = 2'b10;
    tick(15);
    first = -1;
    foreach (rep_q[i]) if (first < 0 && rep_q[i] >= e1 + 3) first = rep_q[i] - e1;
    check("repeat_restart", first, 12);
    check("glitch_no_release", rel_cnt[0], 0);

    // Real release.
    clear_events();
    e2          = edge_cnt;
    bus.btn_raw = 2'b11;
    tick(10);
    check("release_latency0", rel_edge[0] - e2, 6);
    check("release_once0", rel_cnt[0], 1);

    // Bouncing press never reaches the debounce count.
    clear_events();
    bus.btn_raw = 2'b10; tick(3);
    bus.btn_raw = 2'b11; tick(1);
    bus.btn_raw = 2'b10; tick(3);
    bus.btn_raw = 2'b11; tick(10);
    check("bounce_no_press", press_cnt[0], 0);

    // Both buttons pressed together.
    clear_events();
    e3          = edge_cnt;
    bus.btn_raw = 2'b00;
    tick(10);
    check("both_press0", press_edge[0] - e3, 6);
    check("both_press1", press_edge[1] - e3, 6);

    // Reset while held, then a fresh full-latency press.
    tick(5);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    er    = edge_cnt;
    clear_events();
    tick(12);
    check("post_reset_press0", press_edge[0] - er, 6);
    check("post_reset_press1", press_edge[1] - er, 6);
    check("post_reset_once0", press_cnt[0], 1);

    // Randomized pin activity with occasional resets.
    bus.btn_raw = 2'b11;
    tick(10);
    for (int i = 0; i < 150; i++) begin
      bus.btn_raw = 2'($urandom_range(0, 3));
      tick($urandom_range(1, 24));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
      end
    end
    bus.btn_raw = 2'b11;
    tick(20);
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
